// File: rtl/mcast_replay_fifo.sv
// Replay queue for split multicast headers. Holds the remaining destination
// set (DOC remain), source position and source-destination tag of each split
// header, and re-presents them in strict FIFO order to the input arbiter.
// Headers with an empty remaining set never take an entry.

`ifndef MADDR
`define MADDR 7
`endif
`ifndef MSRC_BW
`define MSRC_BW 3
`endif

// Runtime checks on the queue's invariants; kept apart from the datapath.
module mcast_replay_fifo_chk #(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int DEPTH   = 4,
  parameter int PTRW    = 2,
  parameter int DOCW    = 8
) (
  input logic            clk,
  input logic            rst_,
  input logic            pop,
  input logic [PTRW:0]   count,
  input logic            rd_valid,
  input logic [DOCW-1:0] rd_doc
);
  localparam logic [PTRW:0]   DEPTH_C  = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ZERO = (PTRW+1)'(0);
  localparam logic [DOCW-1:0] DOC_ZERO = DOCW'(0);

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_)
    pop |-> (count != CNT_ZERO))
    else $error("replay fifo (%0d,%0d): pop while empty", MY_XPOS, MY_YPOS);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_)
    count <= DEPTH_C)
    else $error("replay fifo (%0d,%0d): count above %0d", MY_XPOS, MY_YPOS, DEPTH);

  a_doc_nonzero: assert property (@(posedge clk) disable iff (!rst_)
    rd_valid |-> (rd_doc != DOC_ZERO))
    else $error("replay fifo (%0d,%0d): valid head with empty DOC", MY_XPOS, MY_YPOS);
endmodule

module mcast_replay_fifo #(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int DEPTH   = 4,
  parameter int PTRW    = 2
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [`MADDR:0]    wr_doc,
  input  logic [1:0]         wr_src_pos,
  input  logic [`MSRC_BW:0]  wr_src_dst,
  output logic               wr_ready,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [`MADDR:0]    rd_doc,
  output logic [1:0]         rd_src_pos,
  output logic [`MSRC_BW:0]  rd_src_dst,
  output logic [PTRW:0]      count,
  output logic               overflow
);
  localparam int DOCW = `MADDR + 1;
  localparam int SRCW = `MSRC_BW + 1;
  localparam int ENTW = DOCW + 2 + SRCW;

  localparam logic [PTRW:0]     DEPTH_C  = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]     CNT_ZERO = (PTRW+1)'(0);
  localparam logic [PTRW:0]     CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0]   PTR_ZERO = PTRW'(0);
  localparam logic [PTRW-1:0]   PTR_ONE  = PTRW'(1);
  localparam logic [DOCW-1:0]   DOC_ZERO = DOCW'(0);

  logic [ENTW-1:0] mem_r [DEPTH];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [PTRW:0]   count_r;
  logic            overflow_r;

  logic            full_s;
  logic            empty_s;
  logic            doc_live_s;
  logic            push_s;
  logic            pop_s;
  logic            ovf_set_s;
  logic [PTRW:0]   count_nxt_s;
  logic [ENTW-1:0] head_s;
  logic [DOCW-1:0] rd_doc_s;
  logic [1:0]      rd_src_pos_s;
  logic [SRCW-1:0] rd_src_dst_s;

  // Push/pop qualification; a full queue still takes a push when the head leaves that cycle.
  always_comb begin
    full_s     = (count_r == DEPTH_C);
    empty_s    = (count_r == CNT_ZERO);
    doc_live_s = (wr_doc != DOC_ZERO);
    pop_s      = ~empty_s & rd_ready;
    push_s     = wr_en & doc_live_s & (~full_s | pop_s);
    ovf_set_s  = wr_en & doc_live_s & full_s & ~pop_s;
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= {wr_doc, wr_src_pos, wr_src_dst};
    end
  end

  // Pointers, count and sticky overflow; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head presentation: fields are zeroed whenever the queue is empty.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (empty_s) begin
      rd_doc_s     = DOC_ZERO;
      rd_src_pos_s = 2'b00;
      rd_src_dst_s = SRCW'(0);
    end else begin
      rd_doc_s     = head_s[ENTW-1 -: DOCW];
      rd_src_pos_s = head_s[SRCW +: 2];
      rd_src_dst_s = head_s[SRCW-1:0];
    end
  end

  assign wr_ready   = ~full_s;
  assign rd_valid   = ~empty_s;
  assign rd_doc     = rd_doc_s;
  assign rd_src_pos = rd_src_pos_s;
  assign rd_src_dst = rd_src_dst_s;
  assign count      = count_r;
  assign overflow   = overflow_r;

  mcast_replay_fifo_chk #(
    .MY_XPOS (MY_XPOS),
    .MY_YPOS (MY_YPOS),
    .DEPTH   (DEPTH),
    .PTRW    (PTRW),
    .DOCW    (DOCW)
  ) u_chk (
    .clk      (clk),
    .rst_     (rst_),
    .pop      (pop_s),
    .count    (count_r),
    .rd_valid (rd_valid),
    .rd_doc   (rd_doc_s)
  );
endmodule
